ppu_scroll_addr: RTL and testbench

Loopy scroll/VRAM address unit of the PPU. It sits directly downstream of the PPU register interface and consumes that block's qualified write strobes for $2000, $2005 and $2006, its $2002 read strobe, and its $2007 access strobe. It holds the temporary address `t`, the current address `v`, fine X scroll `x` and the shared write toggle `w`. It also applies the rendering-time coarse-X/Y increments and horizontal/vertical copies requested by the PPU timing generator, and drives the VRAM address for $2007 accesses and background fetches.

---
 rtl/ppu_scroll_addr_if.sv | 32 +++
 rtl/ppu_scroll_addr.sv | 137 +++++++++++++
 tb/tb_ppu_scroll_addr.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_scroll_addr_if.sv
// Strobe/data bundle between the PPU register block and timing generator and
// the loopy scroll/VRAM address unit.
interface ppu_scroll_addr_if;
  logic        ctrl_wr;
  logic        scroll_wr;
  logic        addr_wr;
  logic        status_rd;
  logic        data_acc;
  logic [7:0]  din;
  logic        inc32;
  logic        rendering;
  logic        inc_hori;
  logic        inc_vert;
  logic        copy_hori;
  logic        copy_vert;
  logic [14:0] vram_addr;
  logic [13:0] ppu_mem_addr;
  logic [2:0]  fine_x;
  logic        write_toggle;

  modport master (
    output ctrl_wr, scroll_wr, addr_wr, status_rd, data_acc, din, inc32,
           rendering, inc_hori, inc_vert, copy_hori, copy_vert,
    input  vram_addr, ppu_mem_addr, fine_x, write_toggle
  );

  modport slave (
    input  ctrl_wr, scroll_wr, addr_wr, status_rd, data_acc, din, inc32,
           rendering, inc_hori, inc_vert, copy_hori, copy_vert,
    output vram_addr, ppu_mem_addr, fine_x, write_toggle
  );
endinterface

// File: rtl/ppu_scroll_addr.sv
// Loopy scroll/VRAM address unit: holds t, v, fine X and the shared write
// toggle, applying CPU register writes and rendering-time increments/copies.
module ppu_scroll_addr (
  input  logic            clk,
  input  logic            rst,
  ppu_scroll_addr_if.slave bus
);

  logic [14:0] t_r, v_r, t_next_s, v_next_s, ren_s, hx_s, vy_s;
  logic [2:0]  x_r, x_next_s;
  logic        w_r, w_next_s;
  logic        acc_s, hinc_s, vinc_s;

  function automatic logic [14:0] inc_coarse_x(input logic [14:0] a);
    logic [14:0] r;
    r = a;
    if (a[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~a[10];
    end else begin
      r[4:0] = a[4:0] + 5'd1;
    end
    return r;
  endfunction

  function automatic logic [14:0] inc_y(input logic [14:0] a);
    logic [14:0] r;
    r = a;
    if (a[14:12] != 3'd7) begin
      r[14:12] = a[14:12] + 3'd1;
    end else begin
      r[14:12] = 3'd0;
      case (a[9:5])
        5'd29: begin
          r[9:5] = 5'd0;
          r[11]  = ~a[11];
        end
        // Coarse Y 30/31 index attribute memory; 31 wraps without a nametable flip.
        5'd31:   r[9:5] = 5'd0;
        default: r[9:5] = a[9:5] + 5'd1;
      endcase
    end
    return r;
  endfunction

  // Next-state logic for t, v, x and w.
  always_comb begin
    t_next_s = t_r;
    x_next_s = x_r;
    w_next_s = w_r;
    acc_s  = bus.data_acc & ~bus.addr_wr & ~bus.scroll_wr & ~bus.ctrl_wr;
    // A $2007 access while rendering bumps both X and Y (hardware glitch).
    hinc_s = bus.rendering & (bus.inc_hori | acc_s);
    vinc_s = bus.rendering & (bus.inc_vert | acc_s);
    hx_s   = inc_coarse_x(v_r);
    vy_s   = inc_y(v_r);

    if (bus.addr_wr) begin
      if (w_r) begin
        t_next_s[7:0] = bus.din;
      end else begin
        t_next_s[14:8] = {1'b0, bus.din[5:0]};
      end
      w_next_s = ~w_r;
    end else if (bus.scroll_wr) begin
      if (w_r) begin
        t_next_s[14:12] = bus.din[2:0];
        t_next_s[9:5]   = bus.din[7:3];
      end else begin
        t_next_s[4:0] = bus.din[7:3];
        x_next_s      = bus.din[2:0];
      end
      w_next_s = ~w_r;
    end else if (bus.ctrl_wr) begin
      t_next_s[11:10] = bus.din[1:0];
    end else begin
      t_next_s = t_r;
    end

    if (bus.status_rd) begin
      w_next_s = 1'b0;
    end else begin
      w_next_s = w_next_s;
    end

    ren_s = v_r;
    if (bus.copy_hori) begin
      ren_s[10]  = t_r[10];
      ren_s[4:0] = t_r[4:0];
    end else if (hinc_s) begin
      ren_s[10]  = hx_s[10];
      ren_s[4:0] = hx_s[4:0];
    end else begin
      ren_s[10]  = v_r[10];
    end
    if (bus.copy_vert) begin
      ren_s[14:11] = t_r[14:11];
      ren_s[9:5]   = t_r[9:5];
    end else if (vinc_s) begin
      ren_s[14:11] = vy_s[14:11];
      ren_s[9:5]   = vy_s[9:5];
    end else begin
      ren_s[9:5]   = v_r[9:5];
    end

    if (bus.addr_wr && w_r) begin
      v_next_s = {t_r[14:8], bus.din};
    end else if (bus.rendering) begin
      v_next_s = ren_s;
    end else if (acc_s) begin
      v_next_s = v_r + (bus.inc32 ? 15'd32 : 15'd1);
    end else begin
      v_next_s = v_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r <= 15'd0;
      v_r <= 15'd0;
      x_r <= 3'd0;
      w_r <= 1'b0;
    end else begin
      t_r <= t_next_s;
      v_r <= v_next_s;
      x_r <= x_next_s;
      w_r <= w_next_s;
    end
  end

  assign bus.vram_addr    = v_r;
  assign bus.ppu_mem_addr = v_r[13:0];
  assign bus.fine_x       = x_r;
  assign bus.write_toggle = w_r;

endmodule

// File: tb/tb_ppu_scroll_addr.sv
// Directed self-checking bench for ppu_scroll_addr.
module tb_ppu_scroll_addr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  ppu_scroll_addr_if bus ();

  ppu_scroll_addr dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #20 clk = ~clk;

  task automatic clear_strobes();
    bus.ctrl_wr = 1'b0; bus.scroll_wr = 1'b0; bus.addr_wr = 1'b0;
    bus.status_rd = 1'b0; bus.data_acc = 1'b0; bus.inc_hori = 1'b0;
    bus.inc_vert = 1'b0; bus.copy_hori = 1'b0; bus.copy_vert = 1'b0;
  endtask

  // Apply currently driven inputs for one edge, sample 1 ns later, drop strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  // Build t from CPU writes, then copy all of it into v.
  task automatic load_v(input logic [14:0] val);
    bus.status_rd = 1'b1; tick();
    bus.ctrl_wr = 1'b1; bus.din = {6'd0, val[11:10]}; tick();
    bus.scroll_wr = 1'b1; bus.din = {val[4:0], 3'd0}; tick();
    bus.scroll_wr = 1'b1; bus.din = {val[9:5], val[14:12]}; tick();
    bus.rendering = 1'b1; bus.copy_hori = 1'b1; bus.copy_vert = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.addr_wr = 1'b1; bus.din = 8'h3F; tick();
    rst = 1'b0;
    tests_run++;
    if (bus.vram_addr !== 15'h0000 || bus.ppu_mem_addr !== 14'h0000 ||
        bus.fine_x !== 3'd0 || bus.write_toggle !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: v=%h mem=%h x=%0d w=%b, required all zero",
               bus.vram_addr, bus.ppu_mem_addr, bus.fine_x, bus.write_toggle);
    end
  endtask

  task automatic test_addr_write();
    bus.rendering = 1'b0;
    bus.addr_wr = 1'b1; bus.din = 8'h21; tick();
    tests_run++;
    if (bus.write_toggle !== 1'b1 || bus.vram_addr !== 15'h0000) begin
      tests_failed++;
      $display("FAIL addr_first: w=%b v=%h, required w=1 v=0000", bus.write_toggle, bus.vram_addr);
    end
    bus.addr_wr = 1'b1; bus.din = 8'h08; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h2108 || bus.ppu_mem_addr !== 14'h2108 || bus.write_toggle !== 1'b0) begin
      tests_failed++;
      $display("FAIL addr_second: v=%h mem=%h w=%b, required 2108 2108 0",
               bus.vram_addr, bus.ppu_mem_addr, bus.write_toggle);
    end
  endtask

  task automatic test_data_inc();
    bus.rendering = 1'b0;
    bus.data_acc = 1'b1; bus.inc32 = 1'b0; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h2109) begin
      tests_failed++;
      $display("FAIL inc1: got %h, required 2109", bus.vram_addr);
    end
    bus.data_acc = 1'b1; bus.inc32 = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h2129) begin
      tests_failed++;
      $display("FAIL inc32: got %h, required 2129", bus.vram_addr);
    end
    load_v(15'h7FFF);
    tests_run++;
    if (bus.vram_addr !== 15'h7FFF || bus.ppu_mem_addr !== 14'h3FFF) begin
      tests_failed++;
      $display("FAIL load_7fff: v=%h mem=%h, required 7fff 3fff", bus.vram_addr, bus.ppu_mem_addr);
    end
    bus.rendering = 1'b0; bus.data_acc = 1'b1; bus.inc32 = 1'b0; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0000) begin
      tests_failed++;
      $display("FAIL wrap1: got %h, required 0000", bus.vram_addr);
    end
    load_v(15'h7FFF);
    bus.rendering = 1'b0; bus.data_acc = 1'b1; bus.inc32 = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h001F) begin
      tests_failed++;
      $display("FAIL wrap32: got %h, required 001f", bus.vram_addr);
    end
  endtask

  task automatic test_scroll();
    bus.rendering = 1'b0;
    bus.status_rd = 1'b1; tick();
    bus.scroll_wr = 1'b1; bus.din = 8'h7D; tick();
    tests_run++;
    if (bus.fine_x !== 3'd5 || bus.write_toggle !== 1'b1) begin
      tests_failed++;
      $display("FAIL scroll_first: x=%0d w=%b, required 5 1", bus.fine_x, bus.write_toggle);
    end
    bus.scroll_wr = 1'b1; bus.din = 8'h5E; tick();
    bus.ctrl_wr = 1'b1; bus.din = 8'h03; tick();
    bus.rendering = 1'b1; bus.copy_hori = 1'b1; bus.copy_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h6D6F || bus.write_toggle !== 1'b0 || bus.fine_x !== 3'd5) begin
      tests_failed++;
      $display("FAIL scroll_copy: v=%h w=%b x=%0d, required 6d6f 0 5",
               bus.vram_addr, bus.write_toggle, bus.fine_x);
    end
  endtask

  task automatic test_toggle_clear();
    bus.rendering = 1'b0;
    bus.status_rd = 1'b1; tick();
    bus.addr_wr = 1'b1; bus.din = 8'h3F; tick();
    bus.status_rd = 1'b1; tick();
    tests_run++;
    if (bus.write_toggle !== 1'b0) begin
      tests_failed++;
      $display("FAIL status_clear: w=%b, required 0", bus.write_toggle);
    end
    bus.addr_wr = 1'b1; bus.din = 8'h20; tick();
    tests_run++;
    if (bus.write_toggle !== 1'b1 || bus.vram_addr !== 15'h6D6F) begin
      tests_failed++;
      $display("FAIL readdr_first: w=%b v=%h, required 1 6d6f", bus.write_toggle, bus.vram_addr);
    end
    bus.addr_wr = 1'b1; bus.din = 8'h00; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h2000) begin
      tests_failed++;
      $display("FAIL readdr_t_high: v=%h, required 2000", bus.vram_addr);
    end
  endtask

  task automatic test_render_inc();
    load_v(15'h701F);
    bus.inc_hori = 1'b1; bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0420) begin
      tests_failed++;
      $display("FAIL hv_inc: got %h, required 0420", bus.vram_addr);
    end
    load_v(15'h73A0);
    bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0800) begin
      tests_failed++;
      $display("FAIL y29: got %h, required 0800", bus.vram_addr);
    end
    load_v(15'h73E0);
    bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0000) begin
      tests_failed++;
      $display("FAIL y31: got %h, required 0000", bus.vram_addr);
    end
  endtask

  task automatic test_glitch_acc();
    load_v(15'h0000);
    bus.data_acc = 1'b1; bus.inc32 = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h1001) begin
      tests_failed++;
      $display("FAIL glitch_acc: got %h, required 1001", bus.vram_addr);
    end
    load_v(15'h0000);
    bus.data_acc = 1'b1; bus.inc_hori = 1'b1; bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h1001) begin
      tests_failed++;
      $display("FAIL glitch_once: got %h, required 1001", bus.vram_addr);
    end
    load_v(15'h0000);
    bus.rendering = 1'b0; bus.data_acc = 1'b1; bus.inc32 = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0020) begin
      tests_failed++;
      $display("FAIL idle_acc32: got %h, required 0020", bus.vram_addr);
    end
  endtask

  task automatic test_overrides();
    load_v(15'h0005);
    bus.inc_hori = 1'b1; tick();
    bus.inc_hori = 1'b1; bus.copy_hori = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0005) begin
      tests_failed++;
      $display("FAIL copy_over_inc: got %h, required 0005", bus.vram_addr);
    end
    bus.rendering = 1'b0;
    bus.inc_hori = 1'b1; bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h0005) begin
      tests_failed++;
      $display("FAIL idle_render: got %h, required 0005", bus.vram_addr);
    end
    bus.rendering = 1'b1;
    bus.status_rd = 1'b1; tick();
    bus.addr_wr = 1'b1; bus.din = 8'h12; tick();
    bus.addr_wr = 1'b1; bus.din = 8'h34; bus.inc_hori = 1'b1; bus.inc_vert = 1'b1; tick();
    tests_run++;
    if (bus.vram_addr !== 15'h1234) begin
      tests_failed++;
      $display("FAIL addr_over_render: got %h, required 1234", bus.vram_addr);
    end
  endtask

  task automatic test_reset_mid();
    bus.rendering = 1'b0;
    bus.addr_wr = 1'b1; bus.din = 8'h15; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    tests_run++;
    if (bus.write_toggle !== 1'b0 || bus.vram_addr !== 15'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid: w=%b v=%h, required 0 0000", bus.write_toggle, bus.vram_addr);
    end
    bus.addr_wr = 1'b1; bus.din = 8'h22; tick();
    tests_run++;
    if (bus.write_toggle !== 1'b1 || bus.vram_addr !== 15'h0000) begin
      tests_failed++;
      $display("FAIL post_reset_first: w=%b v=%h, required 1 0000", bus.write_toggle, bus.vram_addr);
    end
  endtask

  initial begin
    clear_strobes();
    bus.din = 8'h00; bus.inc32 = 1'b0; bus.rendering = 1'b0;
    tick();
    test_reset();
    test_addr_write();
    test_data_inc();
    test_scroll();
    test_toggle_clear();
    test_render_inc();
    test_glitch_acc();
    test_overrides();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
